// File: rtl/cnn_pkg.sv
// Shared constants and types for the padded-feature window generator.
package cnn_pkg;
  localparam int IMG_W      = 128;
  localparam int PAD_W      = 130;
  localparam int PAD_PIXELS = 16900;
  localparam int WIN_W      = 72;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [6:0]       row;
    logic [6:0]       col;
    logic [WIN_W-1:0] data;
  } win_t;

  function automatic logic is_border(input logic [7:0] r, input logic [7:0] c);
    return (r == 8'd0) || (r == 8'(PAD_W - 1)) || (c == 8'd0) || (c == 8'(PAD_W - 1));
  endfunction
endpackage

// File: rtl/line_buffer.sv
// Circular single-row delay line: each shift reads the oldest entry and overwrites it with din.
module line_buffer #(
  parameter int DEPTH = 130,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    ptr_q, ptr_d;

  assign dout = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (shift) ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // Contents are fully rewritten by the first two rows of every run, so no reset.
  always_ff @(posedge clk) begin
    if (shift) mem_q[ptr_q] <= din;
  end
endmodule

// File: rtl/window_3x3_gen.sv
// Scans one 130x130 padded channel and emits all 128x128 3x3 windows through a 2-entry FIFO.
// Build option: WINDOW_PAD_ZERO_FORCE_EN skips border reads and injects zeros in their slots.
module window_3x3_gen
  import cnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        chan_sel,
  output logic              mem_rd,
  output logic [1:0]        mem_sel,
  output logic [14:0]       mem_addr,
  input  logic signed [7:0] mem_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [WIN_W-1:0]  win_data,
  output logic [6:0]        win_row,
  output logic [6:0]        win_col,
  output logic              busy,
  output logic              done,
  output state_e            dbg_state
);
  localparam logic [7:0] LAST_IDX = 8'(PAD_W - 1);

  state_e          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [14:0]     addr_q, addr_d;
  logic [7:0]      row_q, row_d, col_q, col_d;
  logic            rsp_vld_q, rsp_vld_d, rsp_zero_q, rsp_zero_d;
  logic [7:0]      rsp_row_q, rsp_row_d, rsp_col_q, rsp_col_d;
  logic [8:0][7:0] win_q, win_d;
  win_t [1:0]      fifo_q, fifo_d;
  logic            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            issue, last_pos, zero_slot, push, pop;
  logic [7:0]      pix, top_pix, mid_pix;

  assign last_pos = (row_q == LAST_IDX) && (col_q == LAST_IDX);
`ifdef WINDOW_PAD_ZERO_FORCE_EN
  assign zero_slot = is_border(row_q, col_q);
`else
  assign zero_slot = 1'b0;
`endif
  // A slot is issued only while FIFO entries plus the in-flight read leave room for its window.
  assign issue = (state_q == ST_RUN) && ((cnt_q + {1'b0, rsp_vld_q}) < 2'd2);

  assign mem_rd    = issue && !zero_slot;
  assign mem_sel   = sel_q;
  assign mem_addr  = addr_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

  // Output handshake: a window transfers on a cycle where win_valid and win_ready are both high;
  // the head entry is held unchanged until that transfer.
  assign win_valid = (cnt_q != 2'd0);
  assign win_data  = fifo_q[rd_ptr_q].data;
  assign win_row   = fifo_q[rd_ptr_q].row;
  assign win_col   = fifo_q[rd_ptr_q].col;

  assign pix  = rsp_zero_q ? 8'd0 : mem_data;
  assign push = rsp_vld_q && (rsp_row_q >= 8'd2) && (rsp_col_q >= 8'd2);
  assign pop  = win_valid && win_ready;

  line_buffer #(.DEPTH(PAD_W), .WIDTH(8)) u_lb_top (
    .clk(clk), .rst(rst), .shift(rsp_vld_q), .din(mid_pix), .dout(top_pix)
  );
  line_buffer #(.DEPTH(PAD_W), .WIDTH(8)) u_lb_mid (
    .clk(clk), .rst(rst), .shift(rsp_vld_q), .din(pix), .dout(mid_pix)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    row_d      = row_q;
    col_d      = col_q;
    rsp_vld_d  = issue;
    rsp_zero_d = zero_slot;
    rsp_row_d  = row_q;
    rsp_col_d  = col_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_RUN;
        sel_d   = chan_sel;
        addr_d  = '0;
        row_d   = '0;
        col_d   = '0;
      end
      ST_RUN:   if (issue && last_pos) state_d = ST_DRAIN;
      ST_DRAIN: if ((cnt_q == 2'd0) && !rsp_vld_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (issue) begin
      if (last_pos) begin
        addr_d = '0;
        row_d  = '0;
        col_d  = '0;
      end else begin
        addr_d = addr_q + 15'd1;
        if (col_q == LAST_IDX) begin
          col_d = '0;
          row_d = row_q + 8'd1;
        end else begin
          col_d = col_q + 8'd1;
        end
      end
    end
  end

  // Window columns age left; the new column is (row r-2, row r-1, row r) at column c.
  always_comb begin
    win_d = win_q;
    if (rsp_vld_q) begin
      for (int i = 0; i < 3; i++) begin
        win_d[3*i]   = win_q[3*i+1];
        win_d[3*i+1] = win_q[3*i+2];
      end
      win_d[2] = top_pix;
      win_d[5] = mid_pix;
      win_d[8] = pix;
    end
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q].row  = 7'(rsp_row_q - 8'd2);
      fifo_d[wr_ptr_q].col  = 7'(rsp_col_q - 8'd2);
      fifo_d[wr_ptr_q].data = win_d;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      addr_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_zero_q <= 1'b0;
      rsp_row_q  <= '0;
      rsp_col_q  <= '0;
      win_q      <= '0;
      fifo_q     <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      row_q      <= row_d;
      col_q      <= col_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_row_q  <= rsp_row_d;
      rsp_col_q  <= rsp_col_d;
      win_q      <= win_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule
